// File: rtl/fetch_ifid_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, selects the next PC
// (sequential / branch / j / jr), and registers the instruction word into D.
module fetch_ifid_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic [25:0] imm26_D,
  input  logic [31:0] rs_val_D,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        fetch_err_D
);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  // Upper bound kept 33 bits wide so a memory ending exactly at 2^32 compares correctly.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] npc;
  logic [31:0] br_off;
  logic        err_F;
  npc_op_e     op;

  assign op     = npc_op_e'(npc_op);
  assign br_off = {{14{imm26_D[15]}}, imm26_D[15:0], 2'b00};

  // Next-PC select; redirect targets are relative to the instruction in D.
  always_comb begin
    npc = pc_F + 32'd4;
    unique case (op)
      NPC_SEQ:    npc = pc_F + 32'd4;
      NPC_BRANCH: npc = pc_D + 32'd4 + br_off;
      NPC_JUMP:   npc = {pc_D[31:28], imm26_D, 2'b00};
      NPC_JR:     npc = rs_val_D;
      default:    npc = pc_F + 32'd4;
    endcase
  end

  // Fetch address is illegal if misaligned or outside instruction memory.
  always_comb begin
    err_F = (pc_F[1:0] != 2'b00) ||
            (pc_F < IM_BASE) ||
            ({1'b0, pc_F} >= IM_LIMIT);
  end

  // PC and IF/ID register: reset wins, stall holds, else advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_F        <= PC_RESET;
      instr_D     <= '0;
      pc_D        <= PC_RESET;
      fetch_err_D <= 1'b0;
    end else if (!stall) begin
      pc_F        <= npc;
      instr_D     <= err_F ? '0 : imem_rdata;
      pc_D        <= pc_F;
      fetch_err_D <= err_F;
    end
  end

  assign pc8_D = pc_D + 32'd8;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: stimulus pushes the expected
// post-edge state, a monitor pops and compares one entry per clock.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic [25:0] imm26_D;
  logic [31:0] rs_val_D;
  logic [31:0] imem_rdata;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        fetch_err_D;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        err;
    int          step_no;
  } exp_t;

  exp_t exp_q[$];
  int   step_cnt = 0;

  fetch_ifid_stage #(
    .PC_RESET(32'h0000_3000),
    .IM_BASE (32'h0000_3000),
    .IM_WORDS(1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_op     (npc_op),
    .imm26_D    (imm26_D),
    .rs_val_D   (rs_val_D),
    .imem_rdata (imem_rdata),
    .pc_F       (pc_F),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .pc8_D      (pc8_D),
    .fetch_err_D(fetch_err_D)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input int sn, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, sn, act, req);
    end
  endtask

  // Monitor: compare DUT state just after each edge against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32("pc_F",        e.step_no, pc_F,    e.pc_F);
      check32("instr_D",     e.step_no, instr_D, e.instr_D);
      check32("pc_D",        e.step_no, pc_D,    e.pc_D);
      check32("pc8_D",       e.step_no, pc8_D,   e.pc_D + 32'd8);
      check32("fetch_err_D", e.step_no, {31'd0, fetch_err_D}, {31'd0, e.err});
    end
  end

  // Drive one cycle of inputs (well away from the edge) and record the expected result.
  task automatic step(input logic r, input logic st, input logic [1:0] op,
                      input logic [25:0] imm, input logic [31:0] rs, input logic [31:0] rd,
                      input logic [31:0] e_pcf, input logic [31:0] e_ins,
                      input logic [31:0] e_pcd, input logic e_err);
    exp_t e;
    reset      = r;
    stall      = st;
    npc_op     = op;
    imm26_D    = imm;
    rs_val_D   = rs;
    imem_rdata = rd;
    step_cnt++;
    e.pc_F = e_pcf; e.instr_D = e_ins; e.pc_D = e_pcd; e.err = e_err; e.step_no = step_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    //   rst stl op     imm26         rs            rdata          pc_F          instr_D       pc_D          err
    // Reset and sequential fetch
    step(1, 0, 2'b00, 26'h0,       32'h0,       32'h1111_0000, 32'h0000_3000, 32'h0,        32'h0000_3000, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h1111_0000, 32'h0000_3004, 32'h1111_0000, 32'h0000_3000, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h1111_0004, 32'h0000_3008, 32'h1111_0004, 32'h0000_3004, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h1111_0008, 32'h0000_300C, 32'h1111_0008, 32'h0000_3008, 0);
    // beq at pc_D=0x3008, imm16=0xFFFE -> 0x3004; delay slot from 0x300C proceeds
    step(0, 0, 2'b01, 26'h000FFFE, 32'h0,       32'h1111_000C, 32'h0000_3004, 32'h1111_000C, 32'h0000_300C, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h2222_0004, 32'h0000_3008, 32'h2222_0004, 32'h0000_3004, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h2222_0008, 32'h0000_300C, 32'h2222_0008, 32'h0000_3008, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h2222_000C, 32'h0000_3010, 32'h2222_000C, 32'h0000_300C, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h2222_0010, 32'h0000_3014, 32'h2222_0010, 32'h0000_3010, 0);
    // j at pc_D=0x3010, imm26=0x0000C10 -> 0x3040
    step(0, 0, 2'b10, 26'h0000C10, 32'h0,       32'h2222_0014, 32'h0000_3040, 32'h2222_0014, 32'h0000_3014, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h3333_0040, 32'h0000_3044, 32'h3333_0040, 32'h0000_3040, 0);
    // jr to 0x3100 held by two stall cycles
    step(0, 1, 2'b11, 26'h0,       32'h0000_3100, 32'h3333_0044, 32'h0000_3044, 32'h3333_0040, 32'h0000_3040, 0);
    step(0, 1, 2'b11, 26'h0,       32'h0000_3100, 32'h3333_0044, 32'h0000_3044, 32'h3333_0040, 32'h0000_3040, 0);
    step(0, 0, 2'b11, 26'h0,       32'h0000_3100, 32'h3333_0044, 32'h0000_3100, 32'h3333_0044, 32'h0000_3044, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h4444_0100, 32'h0000_3104, 32'h4444_0100, 32'h0000_3100, 0);
    // jr to misaligned 0x3002
    step(0, 0, 2'b11, 26'h0,       32'h0000_3002, 32'h4444_0104, 32'h0000_3002, 32'h4444_0104, 32'h0000_3104, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'hDEAD_BEEF, 32'h0000_3006, 32'h0,        32'h0000_3002, 1);
    // jr to 0x0 (below IM_BASE)
    step(0, 0, 2'b11, 26'h0,       32'h0,       32'hDEAD_BEEF, 32'h0000_0000, 32'h0,        32'h0000_3006, 1);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'hCAFE_F00D, 32'h0000_0004, 32'h0,        32'h0000_0000, 1);
    // upper boundary: last legal word 0x3FFC, first illegal 0x4000
    step(0, 0, 2'b11, 26'h0,       32'h0000_3FFC, 32'hCAFE_F00D, 32'h0000_3FFC, 32'h0,        32'h0000_0004, 1);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h3FFC_0001, 32'h0000_4000, 32'h3FFC_0001, 32'h0000_3FFC, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h5555_5555, 32'h0000_4004, 32'h0,        32'h0000_4000, 1);
    // reset beats stall and a pending branch
    step(1, 1, 2'b01, 26'h000FFFE, 32'h0,       32'h5555_5555, 32'h0000_3000, 32'h0,        32'h0000_3000, 0);
    step(0, 0, 2'b00, 26'h0,       32'h0,       32'h6666_0000, 32'h0000_3004, 32'h6666_0000, 32'h0000_3000, 0);

    reset = 1'b0; stall = 1'b1; npc_op = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC register and computes the next PC: sequential, branch, j/jal, or jr.
- Presents the fetch address to instruction memory and registers the returned word into the D stage.
- instr_D is the word the D-stage field splitter slices into rs/rt/rd/imm16; branch delay slot is architectural (never flushed).

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 1024, instruction memory depth in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; freezes PC and IF/ID.
- npc_op  input  2  from D-stage controller/comparator: 00 PC+4, 01 branch taken, 10 j/jal, 11 jr/jalr.
- imm26_D  input  26  instr_D[25:0] fed back from the D-stage field splitter; imm16 = imm26_D[15:0].
- rs_val_D  input  32  forwarded rs value for jr/jalr.
- imem_rdata  input  32  instruction word at pc_F (combinational IM read).
- pc_F  output  32  current fetch address to IM.
- instr_D  output  32  registered instruction.
- pc_D  output  32  registered PC of instr_D.
- pc8_D  output  32  pc_D+8, link value for jal/jalr.
- fetch_err_D  output  1  registered: instr_D was fetched from a misaligned or out-of-range PC.

Behaviour:
- Reset (clk edge with reset=1) loads:
  - pc_F=PC_RESET, instr_D=0 (nop), pc_D=PC_RESET, fetch_err_D=0.
  - pc8_D is combinational, so it reads PC_RESET+8 after reset.
  - reset overrides stall and npc_op.
- Next-PC (combinational, 32-bit, wrap mod 2^32):
  - 00: pc_F+4.
  - 01: pc_D+4+(sext(imm16)<<2).
  - 10: {pc_D[31:28], imm26_D, 2'b00}.
  - 11: rs_val_D unmodified.
- Redirect targets use pc_D, not pc_F: the instruction in D is the branch/jump. The instruction already fetched at pc_F (the delay slot) proceeds normally.
- Normal cycle (stall=0):
  - pc_F<=next-PC.
  - instr_D<=imem_rdata, pc_D<=pc_F.
  - fetch_err_D<=err_F, where err_F = (pc_F[1:0]!=0) or pc_F<IM_BASE or pc_F>=IM_BASE+4*IM_WORDS.
- Fetch error: when err_F=1, instr_D<=0 (nop substituted) while pc_D still captures pc_F.
- Stall cycle (stall=1): pc_F, instr_D, pc_D and fetch_err_D all hold.
  - npc_op is ignored; the D instruction re-evaluates next cycle with fresh forwarded operands.
  - A redirect requested during a stall takes effect only in the first non-stalled cycle.
- Latency: one cycle from IM read to instr_D; a redirect appears on pc_F one cycle after the branch sits unstalled in D.
- npc_op is sampled every unstalled cycle. X on npc_op while instr_D=nop is not allowed; the controller drives 00 for nop.
- Back-to-back redirects (branch in a delay slot) are architecturally undefined and not required.
- Reset mid-stall or mid-redirect: reset wins and pending redirects are discarded.

Test Plan:
- Reset, then free-run 3 cycles with npc_op=00 -> pc_F sequence 0x3000, 0x3004, 0x3008, 0x300C; instr_D tracks imem_rdata one cycle late; pc8_D=pc_D+8.
- beq taken at pc_D=0x3008, imm16=0xFFFE, npc_op=01 -> next pc_F=0x3004. The delay slot (fetched at 0x300C) still reaches instr_D with pc_D=0x300C.
- j with imm26_D=26'h0000C10, pc_D=0x3010, npc_op=10 -> pc_F=0x0000_3040.
- jr with rs_val_D=0x0000_3100, stall=1 for 2 cycles then 0 -> pc_F and instr_D frozen for both stall cycles; pc_F=0x3100 the cycle after stall drops.
- jr with rs_val_D=0x0000_3002 -> pc_F=0x3002. Next cycle fetch_err_D=1, instr_D=0, pc_D=0x3002. Same result for rs_val_D=0x0000_0000 (below IM_BASE).
- reset asserted while stall=1 and npc_op=01 -> pc_F=0x3000, instr_D=0, fetch_err_D=0 next cycle.
